// File: rtl/operand_fetch_pkg.sv
// Shared width defaults for the operand-fetch stage; every module here
// takes these as parameter defaults so one edit retunes the whole slice.
package operand_fetch_pkg;

  localparam int WORD_SIZE_DEF = 32;
  localparam int REG_INDEX_DEF = 5;
  localparam int OP_WIDTH_DEF  = 6;
  localparam int CNT_WIDTH_DEF = 16;

endpackage : operand_fetch_pkg

// File: rtl/operand_fetch_if.sv
// Registered operand bundle from operand fetch to execute, valid/ready handshake.
// master = operand fetch (producer), slave = execute (consumer).
interface operand_fetch_if
  import operand_fetch_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int REG_INDEX = REG_INDEX_DEF,
  parameter int OP_WIDTH  = OP_WIDTH_DEF
) ();

  logic                 out_valid;
  logic                 out_ready;
  logic [OP_WIDTH-1:0]  out_op;
  logic [REG_INDEX-1:0] out_rd;
  logic [WORD_SIZE-1:0] out_a;
  logic [WORD_SIZE-1:0] out_b;
  logic [WORD_SIZE-1:0] out_c;
  logic [WORD_SIZE-1:0] out_imm;

  modport master (
    output out_valid, out_op, out_rd, out_a, out_b, out_c, out_imm,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_op, out_rd, out_a, out_b, out_c, out_imm,
    output out_ready
  );

endinterface : operand_fetch_if

// File: rtl/operand_fetch_fwd_mux.sv
// Per-operand forwarding select: EX result (if not a pending load), then MEM,
// then the register file. Purely combinational.
module operand_fetch_fwd_mux
  import operand_fetch_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int REG_INDEX = REG_INDEX_DEF
) (
  input  logic [REG_INDEX-1:0] rs,
  input  logic [WORD_SIZE-1:0] rf_val,
  input  logic                 ex_fwd_valid,
  input  logic                 ex_fwd_is_load,
  input  logic [REG_INDEX-1:0] ex_fwd_num,
  input  logic [WORD_SIZE-1:0] ex_fwd_val,
  input  logic                 mem_fwd_valid,
  input  logic [REG_INDEX-1:0] mem_fwd_num,
  input  logic [WORD_SIZE-1:0] mem_fwd_val,
  output logic [WORD_SIZE-1:0] operand
);

  always_comb begin
    // NOTE: default assignment first so no path leaves operand unassigned (no latch).
    operand = rf_val;
    if (ex_fwd_valid && !ex_fwd_is_load && (ex_fwd_num == rs)) begin
      operand = ex_fwd_val;
    end else if (mem_fwd_valid && (mem_fwd_num == rs)) begin
      operand = mem_fwd_val;
    end
  end

endmodule : operand_fetch_fwd_mux

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register-file indexing, EX/MEM forwarding, load-use
// stall, and the registered operand bundle handed to execute.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int REG_INDEX = REG_INDEX_DEF,
  parameter int OP_WIDTH  = OP_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_enable_n,
  input  logic                 flush,

  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_WIDTH-1:0]  in_op,
  input  logic [REG_INDEX-1:0] in_rd,
  input  logic [REG_INDEX-1:0] in_rs1,
  input  logic [REG_INDEX-1:0] in_rs2,
  input  logic [REG_INDEX-1:0] in_rs3,
  input  logic [2:0]           in_use,
  input  logic [WORD_SIZE-1:0] in_imm,

  output logic [REG_INDEX-1:0] get_num1,
  output logic [REG_INDEX-1:0] get_num2,
  output logic [REG_INDEX-1:0] get_num3,
  input  logic [WORD_SIZE-1:0] rf_out1,
  input  logic [WORD_SIZE-1:0] rf_out2,
  input  logic [WORD_SIZE-1:0] rf_out3,

  input  logic                 ex_fwd_valid,
  input  logic                 ex_fwd_is_load,
  input  logic [REG_INDEX-1:0] ex_fwd_num,
  input  logic [WORD_SIZE-1:0] ex_fwd_val,
  input  logic                 mem_fwd_valid,
  input  logic [REG_INDEX-1:0] mem_fwd_num,
  input  logic [WORD_SIZE-1:0] mem_fwd_val,

  operand_fetch_if.master      out_bus,

  output logic [CNT_WIDTH-1:0] stall_count
);

  logic [WORD_SIZE-1:0] sel_a;
  logic [WORD_SIZE-1:0] sel_b;
  logic [WORD_SIZE-1:0] sel_c;
  logic                 load_hit;
  logic                 hazard;
  logic                 accept;

  assign get_num1 = in_rs1;
  assign get_num2 = in_rs2;
  assign get_num3 = in_rs3;

  operand_fetch_fwd_mux #(.WORD_SIZE(WORD_SIZE), .REG_INDEX(REG_INDEX)) u_fwd_a (
    .rs(in_rs1), .rf_val(rf_out1),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_is_load(ex_fwd_is_load),
    .ex_fwd_num(ex_fwd_num), .ex_fwd_val(ex_fwd_val),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_num(mem_fwd_num), .mem_fwd_val(mem_fwd_val),
    .operand(sel_a)
  );

  operand_fetch_fwd_mux #(.WORD_SIZE(WORD_SIZE), .REG_INDEX(REG_INDEX)) u_fwd_b (
    .rs(in_rs2), .rf_val(rf_out2),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_is_load(ex_fwd_is_load),
    .ex_fwd_num(ex_fwd_num), .ex_fwd_val(ex_fwd_val),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_num(mem_fwd_num), .mem_fwd_val(mem_fwd_val),
    .operand(sel_b)
  );

  operand_fetch_fwd_mux #(.WORD_SIZE(WORD_SIZE), .REG_INDEX(REG_INDEX)) u_fwd_c (
    .rs(in_rs3), .rf_val(rf_out3),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_is_load(ex_fwd_is_load),
    .ex_fwd_num(ex_fwd_num), .ex_fwd_val(ex_fwd_val),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_num(mem_fwd_num), .mem_fwd_val(mem_fwd_val),
    .operand(sel_c)
  );

  // A load in EX only blocks sources this instruction actually reads.
  assign load_hit = (in_use[0] && (ex_fwd_num == in_rs1))
                 || (in_use[1] && (ex_fwd_num == in_rs2))
                 || (in_use[2] && (ex_fwd_num == in_rs3));
  assign hazard   = in_valid && ex_fwd_valid && ex_fwd_is_load && load_hit;
  assign in_ready = !flush && !hazard && (!out_bus.out_valid || out_bus.out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_enable_n) begin
    if (!reset_enable_n) begin
      // NOTE: data registers are reset too, so execute never sees X on a stale bundle.
      out_bus.out_valid <= 1'b0;
      out_bus.out_op    <= '0;
      out_bus.out_rd    <= '0;
      out_bus.out_a     <= '0;
      out_bus.out_b     <= '0;
      out_bus.out_c     <= '0;
      out_bus.out_imm   <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      out_bus.out_valid <= 1'b1;
      out_bus.out_op    <= in_op;
      out_bus.out_rd    <= in_rd;
      out_bus.out_a     <= sel_a;
      out_bus.out_b     <= sel_b;
      out_bus.out_c     <= sel_c;
      out_bus.out_imm   <= in_imm;
    end else if (flush || out_bus.out_ready) begin
      out_bus.out_valid <= 1'b0;
    end
  end

  // Flush takes priority over a simultaneous hazard, so that cycle is not counted.
  always_ff @(posedge clk or negedge reset_enable_n) begin
    if (!reset_enable_n) begin
      stall_count <= '0;
    end else if (hazard && !flush && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule : operand_fetch

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: forwarding priority, load-use stall,
// backpressure, flush and asynchronous reset, against hand-computed values.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset_enable_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2, in_rs3;
  logic [2:0]  in_use;
  logic [31:0] in_imm;
  logic [4:0]  get_num1, get_num2, get_num3;
  logic [31:0] rf_out1, rf_out2, rf_out3;
  logic        ex_fwd_valid, ex_fwd_is_load;
  logic [4:0]  ex_fwd_num;
  logic [31:0] ex_fwd_val;
  logic        mem_fwd_valid;
  logic [4:0]  mem_fwd_num;
  logic [31:0] mem_fwd_val;
  logic [15:0] stall_count;
  logic [31:0] rf [32];

  int n_checks = 0;
  int n_fails  = 0;

  operand_fetch_if bus ();

  operand_fetch dut (
    .clk(clk), .reset_enable_n(reset_enable_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_use(in_use), .in_imm(in_imm),
    .get_num1(get_num1), .get_num2(get_num2), .get_num3(get_num3),
    .rf_out1(rf_out1), .rf_out2(rf_out2), .rf_out3(rf_out3),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_is_load(ex_fwd_is_load),
    .ex_fwd_num(ex_fwd_num), .ex_fwd_val(ex_fwd_val),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_num(mem_fwd_num), .mem_fwd_val(mem_fwd_val),
    .out_bus(bus), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  assign rf_out1 = rf[get_num1];
  assign rf_out2 = rf[get_num2];
  assign rf_out3 = rf[get_num3];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[3] = 32'h11; rf[4] = 32'h44; rf[5] = 32'h77;
    flush = 0; in_valid = 0; in_op = 0; in_rd = 0;
    in_rs1 = 0; in_rs2 = 0; in_rs3 = 0; in_use = 0; in_imm = 0;
    ex_fwd_valid = 0; ex_fwd_is_load = 0; ex_fwd_num = 0; ex_fwd_val = 0;
    mem_fwd_valid = 0; mem_fwd_num = 0; mem_fwd_val = 0;
    bus.out_ready = 1;
    reset_enable_n = 0;
    #2;
    check("reset_out_valid", 32'(bus.out_valid), 32'h0);
    check("reset_out_a", bus.out_a, 32'h0);
    check("reset_stall_count", 32'(stall_count), 32'h0);
    #1 reset_enable_n = 1;
    tick();

    // Plain register-file read
    in_valid = 1; in_op = 6'h2a; in_rd = 5'd7; in_imm = 32'h1234;
    in_rs1 = 5'd3; in_use = 3'b001;
    #1;
    check("plain_get_num1", 32'(get_num1), 32'd3);
    check("plain_in_ready", 32'(in_ready), 32'h1);
    tick();
    check("plain_out_valid", 32'(bus.out_valid), 32'h1);
    check("plain_out_a", bus.out_a, 32'h11);
    check("plain_out_op", 32'(bus.out_op), 32'h2a);
    check("plain_out_rd", 32'(bus.out_rd), 32'd7);
    check("plain_out_imm", bus.out_imm, 32'h1234);
    in_valid = 0;
    tick();
    check("plain_drain", 32'(bus.out_valid), 32'h0);

    // Forwarding priority: EX over MEM over register file
    in_valid = 1; in_rs2 = 5'd5; in_rs3 = 5'd5; in_use = 3'b011;
    ex_fwd_valid = 1; ex_fwd_num = 5'd5; ex_fwd_val = 32'h55;
    mem_fwd_valid = 1; mem_fwd_num = 5'd5; mem_fwd_val = 32'h66;
    tick();
    check("prio_ex_b", bus.out_b, 32'h55);
    check("prio_ex_c", bus.out_c, 32'h55);
    check("prio_ex_a_rf", bus.out_a, 32'h11);
    ex_fwd_valid = 0;
    tick();
    check("prio_mem_b", bus.out_b, 32'h66);
    mem_fwd_valid = 0;
    tick();
    check("prio_rf_b", bus.out_b, 32'h77);

    // Index 0 is forwarded like any other register
    in_rs1 = 5'd0; ex_fwd_valid = 1; ex_fwd_num = 5'd0; ex_fwd_val = 32'hab;
    tick();
    check("idx0_fwd_a", bus.out_a, 32'hab);
    ex_fwd_valid = 0; in_rs1 = 5'd3; in_rs3 = 5'd0;

    // Load-use stall on a read source
    in_rs2 = 5'd4; in_use = 3'b010;
    ex_fwd_valid = 1; ex_fwd_is_load = 1; ex_fwd_num = 5'd4; ex_fwd_val = 32'hdead;
    #1;
    check("lu_in_ready", 32'(in_ready), 32'h0);
    tick();
    check("lu_stall_count", 32'(stall_count), 32'd1);
    check("lu_out_valid", 32'(bus.out_valid), 32'h0);
    ex_fwd_valid = 0; ex_fwd_is_load = 0;
    mem_fwd_valid = 1; mem_fwd_num = 5'd4; mem_fwd_val = 32'h99;
    #1;
    check("lu_release_ready", 32'(in_ready), 32'h1);
    tick();
    check("lu_mem_b", bus.out_b, 32'h99);
    check("lu_out_valid2", 32'(bus.out_valid), 32'h1);
    mem_fwd_valid = 0;

    // Load targets an unused source: no stall, load value not forwarded
    in_use = 3'b001;
    ex_fwd_valid = 1; ex_fwd_is_load = 1; ex_fwd_num = 5'd4;
    #1;
    check("nolu_in_ready", 32'(in_ready), 32'h1);
    tick();
    check("nolu_out_b", bus.out_b, 32'h44);
    check("nolu_stall_count", 32'(stall_count), 32'd1);
    ex_fwd_valid = 0; ex_fwd_is_load = 0;

    // Backpressure: hold for two cycles, then exactly one new bundle
    bus.out_ready = 0; in_op = 6'h11; in_rd = 5'd9; in_imm = 32'h5a5a;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'h0);
    tick();
    check("bp_hold1_op", 32'(bus.out_op), 32'h2a);
    check("bp_hold1_valid", 32'(bus.out_valid), 32'h1);
    tick();
    check("bp_hold2_b", bus.out_b, 32'h44);
    check("bp_hold2_ready", 32'(in_ready), 32'h0);
    bus.out_ready = 1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h1);
    tick();
    check("bp_new_op", 32'(bus.out_op), 32'h11);
    check("bp_new_imm", bus.out_imm, 32'h5a5a);
    in_valid = 0;
    tick();
    check("bp_no_dup", 32'(bus.out_valid), 32'h0);

    // Flush with a held bundle, new input and a simultaneous hazard
    in_valid = 1; in_op = 6'h05; in_use = 3'b000;
    tick();
    check("fl_pre_valid", 32'(bus.out_valid), 32'h1);
    flush = 1; in_op = 6'h06; in_use = 3'b010; in_rs2 = 5'd8;
    ex_fwd_valid = 1; ex_fwd_is_load = 1; ex_fwd_num = 5'd8;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'h0);
    tick();
    check("fl_out_valid", 32'(bus.out_valid), 32'h0);
    check("fl_stall_count", 32'(stall_count), 32'd1);
    flush = 0; in_valid = 0; ex_fwd_valid = 0; ex_fwd_is_load = 0;
    tick();
    check("fl_not_accepted", 32'(bus.out_valid), 32'h0);

    // Asynchronous reset during a stall
    in_valid = 1; in_op = 6'h07; in_use = 3'b001; in_rs1 = 5'd3;
    tick();
    bus.out_ready = 0; in_use = 3'b001;
    ex_fwd_valid = 1; ex_fwd_is_load = 1; ex_fwd_num = 5'd3;
    tick();
    check("rst_pre_stall", 32'(stall_count), 32'd2);
    check("rst_pre_a", bus.out_a, 32'h11);
    #2 reset_enable_n = 0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_a", bus.out_a, 32'h0);
    check("rst_out_op", 32'(bus.out_op), 32'h0);
    check("rst_out_imm", bus.out_imm, 32'h0);
    check("rst_stall_count", 32'(stall_count), 32'h0);
    #1 reset_enable_n = 1;
    in_valid = 0; ex_fwd_valid = 0; ex_fwd_is_load = 0; bus.out_ready = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_operand_fetch
